// File: rtl/gigabit_ingress_reader_pkg.sv
// Purpose: shared ingress buffer header layout and reader types (writer uses the same header fields).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package gigabit_ingress_reader_pkg;

    // Header word layout: byte length in [10:0], VLAN ID in [27:16]
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_BITS = 11;
    localparam int HDR_VLAN_LSB = 16;
    localparam int VLAN_BITS    = 12;

    typedef logic [VLAN_BITS-1:0]    vlan_t;
    typedef logic [HDR_LEN_BITS-1:0] frame_len_t;
    typedef logic [8:0]              frame_words_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR_WAIT,
        ST_DATA,
        ST_DRAIN
    } rd_state_e;

    // Tag travelling alongside an outstanding URAM read
    typedef struct packed {
        logic vld;
        logic hdr;
        logic last;
    } rd_tag_t;

    // One output beat as stored in the skid buffer
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    // Number of 64-bit data words carrying a frame of len bytes
    function automatic frame_words_t len_to_words(input frame_len_t len);
        logic [11:0] sum;
        sum = {1'b0, len} + 12'd7;
        return frame_words_t'(sum >> 3);
    endfunction

    // Byte mask of the final beat of a frame of len bytes
    function automatic logic [7:0] last_keep(input frame_len_t len);
        if (len[2:0] == 3'd0) return 8'hFF;
        return (8'h01 << len[2:0]) - 8'h01;
    endfunction

endpackage

// File: rtl/ingress_skid_fifo.sv
// Purpose: small synchronous FIFO holding returned beats ahead of the AXI-stream port, with occupancy count.
// Latency: push visible at the head one cycle later; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; upstream credit keeps it from filling.
module ingress_skid_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 73,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign pop_dat = mem_q[rd_idx_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

    // Next index / occupancy
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (do_push) wr_idx_d = idx_inc(wr_idx_q);
        if (do_pop)  rd_idx_d = idx_inc(rd_idx_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Index and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx_q] <= push_dat;
    end

endmodule

// File: rtl/gigabit_ingress_reader.sv
// Purpose: drains committed frames (header + 64-bit words) from the URAM ingress buffer onto AXI-stream; optional stats via GIGABIT_INGRESS_READER_STATS_EN.
// Latency: header read one cycle after IDLE exit, data reads one per cycle after the header returns RD_LATENCY cycles later.
// Backpressure: reads are issued only while in-flight reads plus skid occupancy leave room, so m_tready stalls never lose beats.
module gigabit_ingress_reader
    import gigabit_ingress_reader_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int ADDR_BITS  = $clog2(DEPTH),
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [ADDR_BITS:0]   wr_ptr_committed,
    output logic [ADDR_BITS:0]   rd_ptr,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [71:0]          rd_data,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [63:0]          m_tdata,
    output logic [7:0]           m_tkeep,
    output logic                 m_tlast,
    output logic [11:0]          m_tdest
`ifdef GIGABIT_INGRESS_READER_STATS_EN
    ,
    output logic [31:0]          stat_frames,
    output logic [47:0]          stat_bytes,
    output logic [15:0]          stat_malformed
`endif
);

    localparam int PW = ADDR_BITS + 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);

    rd_state_e            state_q, state_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        cur_ptr_q, cur_ptr_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    rd_tag_t              rd_tag_q, rd_tag_d;
    rd_tag_t              pipe_q [RD_LATENCY];
    rd_tag_t              pipe_d [RD_LATENCY];
    frame_len_t           len_q, len_d;
    vlan_t                vlan_q, vlan_d;
    frame_words_t         words_q, words_d;
    frame_words_t         issued_q, issued_d;
`ifdef GIGABIT_INGRESS_READER_STATS_EN
    logic [31:0]          stat_frames_q, stat_frames_d;
    logic [47:0]          stat_bytes_q, stat_bytes_d;
    logic [15:0]          stat_malformed_q, stat_malformed_d;
    logic [48:0]          bytes_sum;
`endif

    rd_tag_t              ret;
    beat_t                push_beat, head_beat;
    logic                 skid_empty, skid_push, skid_pop;
    logic [CW-1:0]        skid_count;
    logic                 tlast_acc;
    int                   outstanding;
    logic                 unused_rd_hi;

    assign unused_rd_hi = ^rd_data[71:64];

    // Tag of the read whose data is on rd_data this cycle
    assign ret = pipe_q[RD_LATENCY-1];

    assign skid_push = ret.vld && !ret.hdr;
    assign push_beat = '{data: rd_data[63:0],
                         keep: ret.last ? last_keep(len_q) : 8'hFF,
                         last: ret.last};

    ingress_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_skid (
        .clk      (aclk),
        .rst      (areset),
        .push     (skid_push),
        .push_dat (push_beat),
        .pop      (skid_pop),
        .pop_dat  (head_beat),
        .empty    (skid_empty),
        .count    (skid_count)
    );

    // Outputs masked while empty so idle values are deterministic
    assign m_tvalid  = !skid_empty;
    assign m_tdata   = m_tvalid ? head_beat.data : 64'd0;
    assign m_tkeep   = m_tvalid ? head_beat.keep : 8'd0;
    assign m_tlast   = m_tvalid && head_beat.last;
    assign m_tdest   = vlan_q;
    assign skid_pop  = m_tvalid && m_tready;
    assign tlast_acc = skid_pop && head_beat.last;

    assign rd_ptr  = rd_ptr_q;
    assign rd_en   = rd_tag_q.vld;
    assign rd_addr = rd_addr_q;
`ifdef GIGABIT_INGRESS_READER_STATS_EN
    assign stat_frames    = stat_frames_q;
    assign stat_bytes     = stat_bytes_q;
    assign stat_malformed = stat_malformed_q;
`endif

    // Latency shift register and count of reads whose data has not yet entered the skid buffer
    always_comb begin
        pipe_d[0]   = rd_tag_q;
        outstanding = rd_tag_q.vld ? 1 : 0;
        for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        for (int i = 0; i < RD_LATENCY; i++) outstanding += pipe_q[i].vld ? 1 : 0;
    end

    // Frame FSM: header fetch, paced data reads, release on tlast acceptance
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        cur_ptr_d = cur_ptr_q;
        rd_addr_d = rd_addr_q;
        rd_tag_d  = '0;
        len_d     = len_q;
        vlan_d    = vlan_q;
        words_d   = words_q;
        issued_d  = issued_q;
`ifdef GIGABIT_INGRESS_READER_STATS_EN
        stat_frames_d    = stat_frames_q;
        stat_bytes_d     = stat_bytes_q;
        stat_malformed_d = stat_malformed_q;
        bytes_sum        = {1'b0, stat_bytes_q} + 49'(len_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_ptr_q != wr_ptr_committed) begin
                    rd_tag_d  = '{vld: 1'b1, hdr: 1'b1, last: 1'b0};
                    rd_addr_d = rd_ptr_q[ADDR_BITS-1:0];
                    cur_ptr_d = rd_ptr_q + PW'(1);
                    state_d   = ST_HDR_WAIT;
                end
            end
            ST_HDR_WAIT: begin
                if (ret.vld && ret.hdr) begin
                    len_d    = rd_data[HDR_LEN_LSB +: HDR_LEN_BITS];
                    vlan_d   = rd_data[HDR_VLAN_LSB +: VLAN_BITS];
                    words_d  = len_to_words(len_d);
                    issued_d = '0;
                    if (len_d == '0) begin
                        // Malformed header: skip just the header word
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        state_d  = ST_IDLE;
`ifdef GIGABIT_INGRESS_READER_STATS_EN
                        if (stat_malformed_q != '1) stat_malformed_d = stat_malformed_q + 1'b1;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (issued_q < words_q && (outstanding + int'(skid_count)) < SKID_DEPTH) begin
                    rd_tag_d  = '{vld: 1'b1, hdr: 1'b0, last: (issued_q == words_q - 9'd1)};
                    rd_addr_d = cur_ptr_q[ADDR_BITS-1:0];
                    cur_ptr_d = cur_ptr_q + PW'(1);
                    issued_d  = issued_q + 9'd1;
                    if (issued_q == words_q - 9'd1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tlast_acc) begin
                    rd_ptr_d = rd_ptr_q + PW'(1) + PW'(words_q);
                    state_d  = ST_IDLE;
`ifdef GIGABIT_INGRESS_READER_STATS_EN
                    if (stat_frames_q != '1) stat_frames_d = stat_frames_q + 1'b1;
                    stat_bytes_d = bytes_sum[48] ? '1 : bytes_sum[47:0];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any frame in flight
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            cur_ptr_q <= '0;
            rd_addr_q <= '0;
            rd_tag_q  <= '0;
            len_q     <= '0;
            vlan_q    <= '0;
            words_q   <= '0;
            issued_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
`ifdef GIGABIT_INGRESS_READER_STATS_EN
            stat_frames_q    <= '0;
            stat_bytes_q     <= '0;
            stat_malformed_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            cur_ptr_q <= cur_ptr_d;
            rd_addr_q <= rd_addr_d;
            rd_tag_q  <= rd_tag_d;
            len_q     <= len_d;
            vlan_q    <= vlan_d;
            words_q   <= words_d;
            issued_q  <= issued_d;
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
`ifdef GIGABIT_INGRESS_READER_STATS_EN
            stat_frames_q    <= stat_frames_d;
            stat_bytes_q     <= stat_bytes_d;
            stat_malformed_q <= stat_malformed_d;
`endif
        end
    end

endmodule
